// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter (start, DATA_BITS LSB-first, optional parity, 1-2 stop bits).
// Latency: from idle and empty, the start bit reaches the line 2 edges after the edge that samples we.
// Backpressure: the line never stalls; writes while full are dropped and flagged by a 1-cycle overflow.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_BITS-1:0]            data_in,
  input  logic                            we,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
  output logic                            overflow,
  output logic                            data_out,
  output logic                            busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Reject parameter sets the framing logic cannot produce.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_fifo: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // Serializer state
  state_t               state;
  state_t               state_nxt;
  logic [WW-1:0]        wait_cnt;
  logic [WW-1:0]        wait_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 par_bit;
  logic                 par_nxt;
  logic                 line_nxt;
  logic                 bit_end;

  // Status comes only from registered count, never from this cycle's we.
  assign full     = (count == LW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign push     = we & ~full;
  assign head     = mem[rd_ptr];
  // Parity is taken from the word as it leaves the FIFO; odd parity is the complement of even.
  assign head_par = (PARITY == 2) ? ^head : ~^head;
  assign bit_end  = (wait_cnt == WW'(CLK_DIV - 1));
  assign busy     = (state != IDLE) | ~empty;

  // Word storage; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy and the dropped-write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= we & full;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencing: next state, FIFO pop, shift register and next line level.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    pop       = 1'b0;
    line_nxt  = 1'b1;
    wait_nxt  = (state == IDLE || bit_end) ? '0 : wait_cnt + WW'(1);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shreg_nxt = head;
          par_nxt   = head_par;
          bit_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        line_nxt = 1'b0;
        if (bit_end) begin
          bit_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        line_nxt = shreg[0];
        if (bit_end) begin
          shreg_nxt = shreg >> 1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = PAR;
            end else begin
              state_nxt = STOP;
            end
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
      PAR: begin
        line_nxt = par_bit;
        if (bit_end) begin
          bit_nxt   = '0;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_nxt = '0;
            // Chain straight into the next start bit so queued frames leave with no idle gap.
            if (!empty) begin
              pop       = 1'b1;
              shreg_nxt = head;
              par_nxt   = head_par;
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            bit_nxt = bit_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Serializer registers; the line is registered one cycle behind the state for a glitch-free pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      data_out <= 1'b1;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_nxt;
      data_out <= line_nxt;
    end
  end

endmodule
